uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 157 +++++++++++++++
 tb/tb_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Frames are sent LSB-first, back-to-back while bytes remain queued.
`timescale 1ns/1ps
module uart_tx #(
    parameter int BAUD_MULT  = 10416,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BAUD_MULT);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_MULT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e         state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic           stop_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           nrst_q;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    logic baud_done;
    logic stop_done;
    logic push;
    logic pop;

    assign baud_done = (baud_q == BAUD_LAST);
    assign stop_done = (state_q == STOP) && baud_done && (stop_q == STOP_LAST);
    assign push      = tx_valid && tx_ready;
    // A byte leaves the FIFO either from IDLE or exactly at the end of the last stop bit.
    assign pop       = (count_q != '0) && ((state_q == IDLE) || stop_done);

    assign tx_ready   = nrst_q && (count_q != FIFO_FULL);
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    always_comb begin
        // NOTE: every variable assigned here gets a default first, otherwise a latch is inferred.
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        nrst_q <= nrst;
    end

    // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: clocked state is always assigned with <= so all registers update from pre-edge values.
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q <= baud_done ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            stop_q  <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                            bit_q   <= bit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        if (stop_q == STOP_LAST) begin
                            if (pop) begin
                                shift_q <= mem_q[rd_ptr_q];
                                tx_q    <= 1'b0;
                                state_q <= START;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frame vectors plus hand-written
// sequences for back-to-back, FIFO stall, two stop bits, pointer wrap and reset abort.
`timescale 1ns/1ps
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit period, index 0 = start bit
    } vec_t;

    logic       clk;
    logic       nrst;
    logic [7:0] tx_data    [3];
    logic       tx_valid   [3];
    logic       tx_ready   [3];
    logic       tx_line    [3];
    logic       busy       [3];
    logic [2:0] fifo_count [3];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] rxq0[$];
    logic [7:0] rxq1[$];

    uart_tx #(.BAUD_MULT(16), .FIFO_DEPTH(4), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .nrst(nrst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx(tx_line[0]), .busy(busy[0]), .fifo_count(fifo_count[0])
    );

    uart_tx #(.BAUD_MULT(16), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .nrst(nrst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx(tx_line[1]), .busy(busy[1]), .fifo_count(fifo_count[1])
    );

    uart_tx u_dut2 (
        .clk(clk), .nrst(nrst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx(tx_line[2]), .busy(busy[2]), .fifo_count(fifo_count[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called just after the edge where tx fell; checks first and last cycle of every bit period.
    task automatic check_frame(input int d, input logic [9:0] f, input int nstop, input string name);
        logic e;
        for (int j = 0; j < 9 + nstop; j++) begin
            e = (j < 10) ? f[j] : 1'b1;
            check($sformatf("%s bit%0d first", name, j), 32'(tx_line[d]), 32'(e));
            repeat (15) tick();
            check($sformatf("%s bit%0d last", name, j), 32'(tx_line[d]), 32'(e));
            if (j == 8 + nstop) check($sformatf("%s busy in stop", name), 32'(busy[d]), 32'd1);
            tick();
        end
    endtask

    // Independent line receiver for the two BAUD_MULT=16 instances; samples mid-bit.
    logic       mon_act  [2];
    logic       mon_prev [2];
    int         mon_cnt  [2];
    logic [7:0] mon_sh   [2];

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!nrst) begin
                    mon_act[d]  = 1'b0;
                    mon_prev[d] = 1'b1;
                end else if (!mon_act[d]) begin
                    if (mon_prev[d] && !tx_line[d]) begin
                        mon_act[d] = 1'b1;
                        mon_cnt[d] = 0;
                    end
                    mon_prev[d] = tx_line[d];
                end else begin
                    mon_cnt[d]++;
                    if ((mon_cnt[d] % 16 == 8) && mon_cnt[d] >= 24 && mon_cnt[d] <= 136)
                        mon_sh[d][mon_cnt[d] / 16 - 1] = tx_line[d];
                    if (mon_cnt[d] == 152) begin
                        check($sformatf("rx%0d stop level", d), 32'(tx_line[d]), 32'd1);
                        if (d == 0) rxq0.push_back(mon_sh[d]);
                        else        rxq1.push_back(mon_sh[d]);
                        mon_act[d]  = 1'b0;
                        mon_prev[d] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        vec_t       vecs [5];
        logic [7:0] wb   [13];
        int         k0;
        int         w;
        int         ones;
        time        t0;

        vecs[0] = '{data: 8'h45, frame: 10'b1010001010};
        vecs[1] = '{data: 8'hD6, frame: 10'b1110101100};
        vecs[2] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[3] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[4] = '{data: 8'hA5, frame: 10'b1101001010};

        nrst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            tx_data[d]  = 8'h00;
            tx_valid[d] = 1'b0;
        end
        repeat (3) tick();
        check("reset tx", 32'(tx_line[0]), 32'd1);
        check("reset tx_ready", 32'(tx_ready[0]), 32'd0);
        check("reset busy", 32'(busy[0]), 32'd0);
        check("reset fifo_count", 32'(fifo_count[0]), 32'd0);
        nrst = 1'b1;
        tick();
        check("post-reset tx", 32'(tx_line[0]), 32'd1);
        check("post-reset tx_ready", 32'(tx_ready[0]), 32'd1);
        check("post-reset busy", 32'(busy[0]), 32'd0);

        // Single frames from the vector table.
        for (int i = 0; i < 5; i++) begin
            tx_data[0]  = vecs[i].data;
            tx_valid[0] = 1'b1;
            tick();
            tx_valid[0] = 1'b0;
            check($sformatf("v%0d queued", i), 32'(fifo_count[0]), 32'd1);
            tick();
            check($sformatf("v%0d popped", i), 32'(fifo_count[0]), 32'd0);
            check_frame(0, vecs[i].frame, 1, $sformatf("v%0d", i));
            check($sformatf("v%0d busy after stop", i), 32'(busy[0]), 32'd0);
            check($sformatf("v%0d idle tx", i), 32'(tx_line[0]), 32'd1);
        end
        check("table rx count", 32'(rxq0.size()), 32'd5);
        for (int i = 0; i < 5 && i < rxq0.size(); i++)
            check($sformatf("table rx byte%0d", i), 32'(rxq0[i]), 32'(vecs[i].data));

        // Back-to-back frames: second start bit exactly 160 clocks after the first.
        tx_data[0]  = 8'h45;
        tx_valid[0] = 1'b1;
        tick();
        tx_data[0]  = 8'hD6;
        tick();
        tx_valid[0] = 1'b0;
        check("b2b queued", 32'(fifo_count[0]), 32'd1);
        check_frame(0, vecs[0].frame, 1, "b2b 45");
        check_frame(0, vecs[1].frame, 1, "b2b D6");
        check("b2b busy end", 32'(busy[0]), 32'd0);

        // FIFO fill and stall with tx_valid held high.
        rxq0.delete();
        tx_data[0]  = 8'h01;
        tx_valid[0] = 1'b1;
        tick();
        k0 = cyc;
        for (int b = 2; b <= 5; b++) begin
            tx_data[0] = 8'(b);
            tick();
            check($sformatf("fill count after %0d", b), 32'(fifo_count[0]), 32'(b - 1));
        end
        check("full tx_ready", 32'(tx_ready[0]), 32'd0);
        tx_data[0] = 8'h06;
        w = 0;
        while (!tx_ready[0] && w < 300) begin
            tick();
            w++;
        end
        tick();
        tx_valid[0] = 1'b0;
        check("06 accept edge", 32'(cyc - k0), 32'd162);
        check("06 count", 32'(fifo_count[0]), 32'd4);
        w = 0;
        while (busy[0] && w < 2000) begin
            tick();
            w++;
        end
        check("fill drain busy", 32'(busy[0]), 32'd0);
        check("fill rx count", 32'(rxq0.size()), 32'd6);
        for (int i = 0; i < 6 && i < rxq0.size(); i++)
            check($sformatf("fill rx byte%0d", i), 32'(rxq0[i]), 32'(i + 1));

        // Two stop bits: 32-clock stop interval before the next start bit.
        tx_data[1]  = 8'hFF;
        tx_valid[1] = 1'b1;
        tick();
        tx_data[1]  = 8'h00;
        tick();
        tx_valid[1] = 1'b0;
        check_frame(1, vecs[3].frame, 2, "s2 FF");
        check_frame(1, vecs[2].frame, 2, "s2 00");
        check("s2 busy end", 32'(busy[1]), 32'd0);

        // Pointer wrap over 13 pushes with flow control honoured.
        rxq1.delete();
        for (int i = 0; i < 13; i++) begin
            wb[i]       = 8'(i * 37 + 5);
            tx_data[1]  = wb[i];
            tx_valid[1] = 1'b1;
            w = 0;
            while (!tx_ready[1] && w < 400) begin
                tick();
                w++;
            end
            if (w == 400) check($sformatf("wrap push%0d timeout", i), 32'(w), 32'd0);
            tick();
            tx_valid[1] = 1'b0;
        end
        w = 0;
        while (busy[1] && w < 4000) begin
            tick();
            w++;
        end
        check("wrap drain busy", 32'(busy[1]), 32'd0);
        check("wrap rx count", 32'(rxq1.size()), 32'd13);
        for (int i = 0; i < 13 && i < rxq1.size(); i++)
            check($sformatf("wrap rx byte%0d", i), 32'(rxq1[i]), 32'(wb[i]));

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        rxq0.delete();
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        tick();
        tx_data[0]  = 8'h11;
        tick();
        tx_data[0]  = 8'h22;
        tick();
        tx_valid[0] = 1'b0;
        check("abort queued", 32'(fifo_count[0]), 32'd2);
        repeat (69) tick();
        check("abort bit3 level", 32'(tx_line[0]), 32'd0);
        nrst = 1'b0;
        tick();
        check("abort tx", 32'(tx_line[0]), 32'd1);
        check("abort count", 32'(fifo_count[0]), 32'd0);
        check("abort busy", 32'(busy[0]), 32'd0);
        check("abort tx_ready", 32'(tx_ready[0]), 32'd0);
        nrst = 1'b1;
        tick();
        check("abort ready again", 32'(tx_ready[0]), 32'd1);
        ones = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx_line[0] === 1'b1 && busy[0] === 1'b0) ones++;
            tick();
        end
        check("abort stays idle", 32'(ones), 32'd400);
        check("abort no rx", 32'(rxq0.size()), 32'd0);

        // Default timing: start bit lasts 10416 clocks (104160 ns).
        tx_data[2]  = 8'h45;
        tx_valid[2] = 1'b1;
        tick();
        tx_valid[2] = 1'b0;
        tick();
        t0 = $time;
        check("dflt start first", 32'(tx_line[2]), 32'd0);
        repeat (10415) tick();
        check("dflt start last", 32'(tx_line[2]), 32'd0);
        tick();
        check("dflt bit0", 32'(tx_line[2]), 32'd1);
        check("dflt start ns", 32'($time - t0), 32'd104160);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
